// File: rtl/vram_arbiter.sv
// Character-RAM arbiter: fixed-priority display fetch over a 2-entry host
// request FIFO, registered RAM strobes and a tagged 2-stage read-return pipe.
module vram_arbiter #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_starve,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned WaitW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(STARVE_LIMIT);

  typedef enum logic [1:0] {GntNone, GntDisp, GntHost} gnt_e;
  typedef enum logic [1:0] {TagNone, TagDisp, TagHost} tag_e;

  logic              fifo_we_q    [2];
  logic [ADDR_W-1:0] fifo_addr_q  [2];
  logic [DATA_W-1:0] fifo_wdata_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  gnt_e              gnt;
  logic              push;
  logic              pop;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  tag_e              tag1_q;
  tag_e              tag2_q;
  logic [WaitW-1:0]  wait_q;

  // Fixed-priority grant and FIFO handshake for the current cycle.
  always_comb begin
    gnt = GntNone;
    if (disp_req) begin
      gnt = GntDisp;
    end else if (count_q != 2'd0) begin
      gnt = GntHost;
    end
    host_ready = (count_q != 2'd2);
    push       = host_valid && host_ready;
    pop        = (gnt == GntHost);
    head_we    = fifo_we_q[rd_ptr_q];
    head_addr  = fifo_addr_q[rd_ptr_q];
    head_wdata = fifo_wdata_q[rd_ptr_q];
  end

  // Host request FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_we_q[i]    <= 1'b0;
        fifo_addr_q[i]  <= '0;
        fifo_wdata_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_we_q[wr_ptr_q]    <= host_we;
        fifo_addr_q[wr_ptr_q]  <= host_addr;
        fifo_wdata_q[wr_ptr_q] <= host_wdata;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered RAM strobes plus the first read-return tag stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      tag1_q    <= TagNone;
    end else begin
      unique case (gnt)
        GntDisp: begin
          ram_en   <= 1'b1;
          ram_we   <= 1'b0;
          ram_addr <= disp_addr;
          tag1_q   <= TagDisp;
        end
        GntHost: begin
          ram_en    <= 1'b1;
          ram_we    <= head_we;
          ram_addr  <= head_addr;
          ram_wdata <= head_wdata;
          tag1_q    <= head_we ? TagNone : TagHost;
        end
        default: begin
          // Address and write data hold their last values when idle.
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          tag1_q <= TagNone;
        end
      endcase
    end
  end

  // Second tag stage aligns with ram_rdata; capture into the tagged requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag2_q      <= TagNone;
      disp_valid  <= 1'b0;
      disp_data   <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      tag2_q      <= tag1_q;
      disp_valid  <= (tag2_q == TagDisp);
      host_rvalid <= (tag2_q == TagHost);
      if (tag2_q == TagDisp) begin
        disp_data <= ram_rdata;
      end
      if (tag2_q == TagHost) begin
        host_rdata <= ram_rdata;
      end
    end
  end

  // Host-head wait counter and sticky starvation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q      <= '0;
      host_starve <= 1'b0;
    end else begin
      if (pop) begin
        wait_q <= '0;
      end else if ((count_q != 2'd0) && (wait_q != WaitMax)) begin
        wait_q <= wait_q + 1'b1;
      end
      if (wait_q == WaitMax) begin
        host_starve <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus pushes expected RAM writes and
// read returns (with their due cycle); a negedge monitor pops and compares.
module tb_vram_arbiter;

  localparam int unsigned ADDR_W       = 12;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned STARVE_LIMIT = 800;

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              host_starve;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .host_starve(host_starve),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Single-port RAM model: unwritten cells read back their own low address bits.
  logic [DATA_W-1:0] mem     [1 << ADDR_W];
  bit                wr_mask [1 << ADDR_W];
  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      wr_mask[ram_addr] <= 1'b1;
    end
    if (ram_en && !ram_we) begin
      ram_rdata <= wr_mask[ram_addr] ? mem[ram_addr] : ram_addr[DATA_W-1:0];
    end
  end

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t disp_q[$];
  exp_t host_q[$];
  exp_t wr_q[$];
  exp_t me;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input int c, input int a, input int d);
    exp_t e;
    e.cyc  = c;
    e.addr = ADDR_W'(a);
    e.data = DATA_W'(d);
    if (kind == 0) disp_q.push_back(e);
    else if (kind == 1) host_q.push_back(e);
    else wr_q.push_back(e);
  endtask

  // Monitor: every valid/write the DUT presents must match the queue head.
  always @(negedge clk) begin
    if (disp_valid === 1'b1) begin
      if (disp_q.size() == 0) chk("disp_unexpected", 1, 0);
      else begin
        me = disp_q.pop_front();
        chk("disp_cycle", cyc, me.cyc);
        chk("disp_data", 32'(disp_data), 32'(me.data));
      end
    end
    if (host_rvalid === 1'b1) begin
      if (host_q.size() == 0) chk("host_rvalid_unexpected", 1, 0);
      else begin
        me = host_q.pop_front();
        chk("host_rcycle", cyc, me.cyc);
        chk("host_rdata", 32'(host_rdata), 32'(me.data));
      end
    end
    if (ram_en === 1'b1 && ram_we === 1'b1) begin
      if (wr_q.size() == 0) chk("ram_write_unexpected", 32'(ram_addr), 32'hffff_ffff);
      else begin
        me = wr_q.pop_front();
        chk("wr_cycle", cyc, me.cyc);
        chk("wr_addr", 32'(ram_addr), 32'(me.addr));
        chk("wr_data", 32'(ram_wdata), 32'(me.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    disp_req   = 1'b0;
    host_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ram_en"}, 32'(ram_en), 0);
    chk({p, "_ram_we"}, 32'(ram_we), 0);
    chk({p, "_ram_addr"}, 32'(ram_addr), 0);
    chk({p, "_ram_wdata"}, 32'(ram_wdata), 0);
    chk({p, "_disp_valid"}, 32'(disp_valid), 0);
    chk({p, "_host_rvalid"}, 32'(host_rvalid), 0);
    chk({p, "_disp_data"}, 32'(disp_data), 0);
    chk({p, "_host_rdata"}, 32'(host_rdata), 0);
    chk({p, "_host_starve"}, 32'(host_starve), 0);
    chk({p, "_host_ready"}, 32'(host_ready), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    int idx;
    bit acc;
    rst        = 1'b1;
    disp_req   = 1'b0;
    disp_addr  = '0;
    host_valid = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    repeat (3) tick();
    chk_reset("reset");
    rst = 1'b0;
    idle(2);

    // Display-only stream: addr 0..79, data = addr, 3-cycle latency.
    for (int i = 0; i < 80; i++) begin
      disp_req  = 1'b1;
      disp_addr = ADDR_W'(i);
      push_exp(0, cyc + 3, i, i);
      tick();
    end
    idle(8);

    // Idle host write lands on the RAM two cycles after acceptance.
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_addr  = 12'h005;
    host_wdata = 8'h41;
    chk("idle_ready", 32'(host_ready), 1);
    push_exp(2, cyc + 2, 'h005, 'h41);
    tick();
    idle(6);

    // Contention: 10-cycle display burst while the host offers 3 writes.
    c   = cyc;
    idx = 0;
    push_exp(2, c + 11, 'h200, 'ha0);
    push_exp(2, c + 12, 'h201, 'ha1);
    push_exp(2, c + 13, 'h202, 'ha2);
    for (int i = 0; i < 16; i++) begin
      disp_req  = (i < 10);
      disp_addr = ADDR_W'(80 + i);
      if (i < 10) push_exp(0, cyc + 3, 80 + i, 80 + i);
      host_valid = (idx < 3);
      host_we    = 1'b1;
      host_addr  = ADDR_W'(32'h200 + idx);
      host_wdata = DATA_W'(32'ha0 + idx);
      @(negedge clk);
      if (i == 1) chk("cont_ready_high", 32'(host_ready), 1);
      if (i == 2) chk("cont_ready_low_full", 32'(host_ready), 0);
      if (i == 10) chk("cont_ready_low_pop", 32'(host_ready), 0);
      acc = host_valid && host_ready;
      tick();
      if (acc) idx++;
    end
    chk("cont_all_accepted", idx, 3);
    idle(6);

    // Read-after-write to 0x100 returns the new data exactly once.
    c          = cyc;
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_addr  = 12'h100;
    host_wdata = 8'h5a;
    push_exp(2, c + 2, 'h100, 'h5a);
    push_exp(1, c + 5, 'h100, 'h5a);
    tick();
    host_we = 1'b0;
    chk("raw_ready", 32'(host_ready), 1);
    tick();
    idle(8);

    // Starvation: display hogs the RAM while a host write waits.
    c = cyc;
    for (int i = 0; i < 810; i++) begin
      disp_req   = 1'b1;
      disp_addr  = ADDR_W'(32'h400 + (i % 128));
      push_exp(0, cyc + 3, 'h400 + (i % 128), i % 128);
      host_valid = (i == 0);
      host_we    = 1'b1;
      host_addr  = 12'h300;
      host_wdata = 8'h77;
      if (i == 5) chk("starve_low_early", 32'(host_starve), 0);
      if (i == 805) chk("starve_high", 32'(host_starve), 1);
      tick();
    end
    push_exp(2, c + 811, 'h300, 'h77);
    idle(10);
    chk("starve_sticky", 32'(host_starve), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("starve_cleared", 32'(host_starve), 0);
    idle(3);

    // Reset mid-operation: in-flight reads and queued writes are dropped.
    disp_req   = 1'b1;
    disp_addr  = 12'h007;
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_addr  = 12'h310;
    host_wdata = 8'h11;
    tick();
    disp_addr  = 12'h008;
    host_addr  = 12'h311;
    host_wdata = 8'h22;
    tick();
    rst        = 1'b1;
    disp_req   = 1'b0;
    host_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk_reset("rst_mid");
    idle(10);

    chk("drain_disp", disp_q.size(), 0);
    chk("drain_host", host_q.size(), 0);
    chk("drain_wr", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
